// File: rtl/fetch_unit.sv
// Y86-64 SEQ fetch stage: assembles 1/2/9/10-byte instructions from a byte-wide
// registered instruction memory and hands them to decode over valid/ready.
module fetch_unit #(
    parameter int unsigned PC_W  = 64,
    parameter logic [3:0]  NOREG = 4'hF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_in,
    input  logic            pc_load,
    output logic            imem_rd,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    input  logic            imem_err,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [3:0]      icode,
    output logic [3:0]      ifun,
    output logic [3:0]      rA,
    output logic [3:0]      rB,
    output logic [PC_W-1:0] valC,
    output logic [PC_W-1:0] valP,
    output logic            instr_invalid,
    output logic            instr_error
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE, HALTED} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [3:0]      cnt;
    logic [3:0]      cur_icode;
    logic [3:0]      cur_len;
    logic [3:0]      byte_idx;
    logic            start, capture, finish, err_hit, err_done;
    logic            handshake, halt_cond;
    logic            reg_en, vc_en;
    logic [3:0]      vc_pos;

    function automatic logic [3:0] len_of(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:        return 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:  return 4'd2;
            4'h7, 4'h8:              return 4'd9;
            4'h3, 4'h4, 4'h5:        return 4'd10;
            default:                 return 4'd1;
        endcase
    endfunction

    // In cycle cnt the memory returns byte cnt-1; byte 0 is decoded straight off the bus.
    always_comb begin
        byte_idx  = cnt - 4'd1;
        cur_icode = (cnt == 4'd1) ? imem_data[7:4] : icode;
        cur_len   = len_of(cur_icode);
        handshake = instr_valid && instr_ready;
        halt_cond = (icode == 4'h0) || instr_invalid || instr_error;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        err_hit   = 1'b0;
        err_done  = 1'b0;
        imem_rd   = 1'b0;
        imem_addr = '0;
        case (state)
            IDLE: begin
                if (pc_load) begin
                    start     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (pc_load) begin
                    start = 1'b1;
                end else if (instr_error) begin
                    // error byte was seen last edge; present what was captured
                    err_done  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    imem_rd = (cnt <= 4'd1) || (cnt < len_of(icode));
                    if (imem_rd) imem_addr = pc + PC_W'(cnt);
                    if (cnt != 4'd0) begin
                        if (imem_err) begin
                            err_hit = 1'b1;
                        end else begin
                            capture = 1'b1;
                            if (byte_idx == cur_len - 4'd1) begin
                                finish    = 1'b1;
                                state_nxt = DONE;
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (handshake) begin
                    if (halt_cond) begin
                        state_nxt = HALTED;
                    end else if (pc_load) begin
                        start     = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (pc_load) begin
                    start     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HALTED: ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        reg_en = capture && (cnt == 4'd2) && ((cur_len == 4'd2) || (cur_len == 4'd10));
        vc_en  = 1'b0;
        vc_pos = '0;
        if (cur_len == 4'd10) begin
            vc_en  = capture && (cnt >= 4'd3);
            vc_pos = cnt - 4'd3;
        end else if (cur_len == 4'd9) begin
            vc_en  = capture && (cnt >= 4'd2);
            vc_pos = cnt - 4'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= '0;
            cnt           <= '0;
            instr_valid   <= 1'b0;
            icode         <= '0;
            ifun          <= '0;
            rA            <= NOREG;
            rB            <= NOREG;
            valC          <= '0;
            valP          <= '0;
            instr_invalid <= 1'b0;
            instr_error   <= 1'b0;
        end else if (start) begin
            pc            <= pc_in;
            cnt           <= '0;
            instr_valid   <= 1'b0;
            icode         <= '0;
            ifun          <= '0;
            rA            <= NOREG;
            rB            <= NOREG;
            valC          <= '0;
            valP          <= '0;
            instr_invalid <= 1'b0;
            instr_error   <= 1'b0;
        end else begin
            if (state == FETCH && cnt != 4'hF) cnt <= cnt + 4'd1;
            if (err_hit) instr_error <= 1'b1;
            if (capture && cnt == 4'd1) begin
                {icode, ifun} <= imem_data;
                instr_invalid <= (imem_data[7:4] > 4'hB);
            end
            if (reg_en) {rA, rB} <= imem_data;
            for (int unsigned i = 0; i < 8; i++) begin
                if (vc_en && vc_pos == 4'(i)) valC[8*i +: 8] <= imem_data;
            end
            if (finish) begin
                instr_valid <= 1'b1;
                valP        <= pc + PC_W'(cur_len);
            end
            if (err_done)  instr_valid <= 1'b1;
            if (handshake) instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle registered byte memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_in;
    logic        pc_load;
    logic        imem_rd;
    logic [63:0] imem_addr;
    logic [7:0]  imem_data;
    logic        imem_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_invalid, instr_error;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [logic [63:0]];
    logic        err_en;
    logic [63:0] err_addr;
    int          rd_cnt;
    logic [63:0] addr_q [$];

    fetch_unit #(.PC_W(64), .NOREG(4'hF)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_load(pc_load),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_err(imem_err), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_invalid(instr_invalid), .instr_error(instr_error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_byte(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (imem_rd) begin
            imem_data <= rd_byte(imem_addr);
            imem_err  <= err_en && (imem_addr == err_addr);
            rd_cnt    <= rd_cnt + 1;
            addr_q.push_back(imem_addr);
        end else begin
            imem_err  <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] base, input int n, input logic [79:0] bytes);
        for (int i = 0; i < n; i++) mem[base + 64'(i)] = bytes[8*(n-1-i) +: 8];
    endtask

    task automatic clear_mon();
        rd_cnt = 0;
        addr_q.delete();
    endtask

    task automatic start_fetch(input logic [63:0] pc);
        pc_in   = pc;
        pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int edges);
        edges = 0;
        while (!instr_valid && edges < 30) begin
            tick();
            edges++;
        end
        if (!instr_valid) check({tag, "_timeout"}, 64'(instr_valid), 64'd1);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        pc_load     = 1'b0;
        instr_ready = 1'b0;
        err_en      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        mem.delete();
        clear_mon();
    endtask

    int edges;

    initial begin
        pc_in = '0; pc_load = 1'b0; instr_ready = 1'b0; err_en = 1'b0;
        err_addr = '0; imem_data = '0; imem_err = 1'b0; rd_cnt = 0;
        do_reset();

        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_rd",    64'(imem_rd), 64'd0);
        check("rst_rArB",  {56'd0, rA, rB}, 64'hFF);
        check("rst_icode", {56'd0, icode, ifun}, 64'h00);
        check("rst_valC",  valC, 64'd0);
        check("rst_valP",  valP, 64'd0);
        check("rst_flags", {62'd0, instr_invalid, instr_error}, 64'd0);

        // irmovq-style 10-byte instruction at 0
        load(64'h0, 10, 80'h30F0EFCDAB8967452301);
        clear_mon();
        start_fetch(64'h0);
        wait_valid("t1", edges);
        check("t1_edges", 64'(edges + 0), 64'd11);
        check("t1_rdcnt", 64'(rd_cnt), 64'd10);
        for (int i = 0; i < 10; i++)
            check("t1_addr", (i < addr_q.size()) ? addr_q[i] : 64'hDEAD, 64'(i));
        check("t1_icode", {56'd0, icode, ifun}, 64'h30);
        check("t1_rArB",  {56'd0, rA, rB}, 64'hF0);
        check("t1_valC",  valC, 64'h0123456789ABCDEF);
        check("t1_valP",  valP, 64'd10);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t1_drop", 64'(instr_valid), 64'd0);

        // jmp, 9 bytes
        load(64'h20, 9, 80'h700001000000000000);
        clear_mon();
        start_fetch(64'h20);
        wait_valid("t2", edges);
        check("t2_edges", 64'(edges), 64'd10);
        check("t2_rdcnt", 64'(rd_cnt), 64'd9);
        check("t2_icode", {56'd0, icode, ifun}, 64'h70);
        check("t2_rArB",  {56'd0, rA, rB}, 64'hFF);
        check("t2_valC",  valC, 64'h100);
        check("t2_valP",  valP, 64'h29);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // 2-byte OPq with decode stalling
        load(64'h40, 2, 80'h6023);
        clear_mon();
        start_fetch(64'h40);
        wait_valid("t3", edges);
        check("t3_edges", 64'(edges), 64'd3);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_v",  64'(instr_valid), 64'd1);
            check("t3_hold_f",  {48'd0, icode, ifun, rA, rB}, 64'h6023);
            check("t3_hold_P",  valP, 64'h42);
            check("t3_hold_rd", 64'(imem_rd), 64'd0);
            tick();
        end
        check("t3_rdcnt", 64'(rd_cnt), 64'd2);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t3_drop", 64'(instr_valid), 64'd0);

        // redirect mid-fetch to a nop at 0x80
        mem.delete();
        load(64'h0, 10, 80'h30F0EFCDAB8967452301);
        load(64'h80, 1, 80'h10);
        start_fetch(64'h0);
        repeat (4) tick();
        start_fetch(64'h80);
        wait_valid("t4", edges);
        check("t4_edges", 64'(edges), 64'd2);
        check("t4_icode", {56'd0, icode, ifun}, 64'h10);
        check("t4_rArB",  {56'd0, rA, rB}, 64'hFF);
        check("t4_valC",  valC, 64'd0);
        check("t4_valP",  valP, 64'h81);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // invalid opcode halts the fetch unit
        load(64'h90, 1, 80'hC0);
        start_fetch(64'h90);
        wait_valid("t5", edges);
        check("t5_inv",   64'(instr_invalid), 64'd1);
        check("t5_icode", 64'(icode), 64'hC);
        check("t5_valP",  valP, 64'h91);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        clear_mon();
        start_fetch(64'h40);
        repeat (4) tick();
        check("t5_halt_rd", 64'(rd_cnt), 64'd0);
        check("t5_halt_v",  64'(instr_valid), 64'd0);

        // memory error on byte 3 of rmmovq
        do_reset();
        load(64'h60, 10, 80'h40120807060504030201);
        err_en   = 1'b1;
        err_addr = 64'h63;
        start_fetch(64'h60);
        edges = 0;
        while (!instr_error && edges < 30) begin
            tick();
            edges++;
        end
        check("t6_err_edge", 64'(edges), 64'd5);
        check("t6_err_v",    64'(instr_valid), 64'd0);
        tick();
        check("t6_valid", 64'(instr_valid), 64'd1);
        check("t6_fields", {48'd0, icode, ifun, rA, rB}, 64'h4012);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        err_en = 1'b0;
        clear_mon();
        start_fetch(64'h0);
        repeat (3) tick();
        check("t6_halt_rd", 64'(rd_cnt), 64'd0);

        // PC wrap on a halt at the top of the address space
        do_reset();
        load(64'hFFFF_FFFF_FFFF_FFFF, 1, 80'h00);
        start_fetch(64'hFFFF_FFFF_FFFF_FFFF);
        wait_valid("t7", edges);
        check("t7_edges", 64'(edges), 64'd2);
        check("t7_valP",  valP, 64'd0);
        check("t7_icode", {56'd0, icode, ifun}, 64'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
